// File: rtl/line_follow_ctrl_n.sv
// Line-following motor controller: proportional steering, PWM, node detection/turns, lost-line search.
// Define LINE_FOLLOW_BRAKE_EN to drive active brake (all direction/enable pins high) in IDLE and STOP.
module line_follow_ctrl_n #(
  parameter int NUM_SENSORS   = 5,
  parameter int PWM_WIDTH     = 8,
  parameter int BASE_DUTY     = 160,
  parameter int GAIN          = 24,
  parameter int TURN_DUTY     = 140,
  parameter int NODE_DEBOUNCE = 4,
  parameter int TURN_MIN      = 2000,
  parameter int LOST_TIMEOUT  = 50000,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] line_sensor,
  input  logic                   robot_enabled,
  input  logic [1:0]             turn_direction,
  output logic                   enA,
  output logic                   enB,
  output logic                   in1,
  output logic                   in2,
  output logic                   in3,
  output logic                   in4,
  output logic                   node_pulse,
  output logic [CNT_WIDTH-1:0]   node_count,
  output logic                   fault,
  output logic [2:0]             state
);

  localparam int C        = (NUM_SENSORS - 1) / 2;
  localparam int DUTY_MAX = (1 << PWM_WIDTH) - 1;
  localparam int TMR_MAX  = (TURN_MIN > LOST_TIMEOUT) ? TURN_MIN : LOST_TIMEOUT;
  localparam int TMR_W    = $clog2(TMR_MAX + 2);
  localparam int DEB_W    = $clog2(NODE_DEBOUNCE + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FOLLOW = 3'd1,
    S_NODE   = 3'd2,
    S_TURN   = 3'd3,
    S_SEARCH = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t               state_r, state_next;
  logic [DEB_W-1:0]     deb_cnt;
  logic                 armed;
  logic [TMR_W-1:0]     timer;
  logic [1:0]           dir_lat;
  logic                 last_left;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] duty_a_lat, duty_b_lat;
  logic [PWM_WIDTH-1:0] tgt_a, tgt_b, eff_a, eff_b;
  logic [PWM_WIDTH-1:0] steer_a, steer_b;
  logic [3:0]           dir_q, dir_n;
  logic [1:0]           en_q, en_n;
  logic                 spin_left;
  logic                 all_ones, all_zero, centre;
  int                   cnt_l, cnt_r, diff, raw_a, raw_b;

  assign all_ones = &line_sensor;
  assign all_zero = ~|line_sensor;
  assign centre   = line_sensor[C];

  // Imbalance between the two halves of the array drives a signed duty correction.
  always_comb begin
    cnt_l = 0;
    cnt_r = 0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (i > C && line_sensor[i]) cnt_l = cnt_l + 1;
      if (i < C && line_sensor[i]) cnt_r = cnt_r + 1;
    end
    diff  = cnt_r - cnt_l;
    raw_a = BASE_DUTY + GAIN * diff;
    raw_b = BASE_DUTY - GAIN * diff;
    if (raw_a < 0)             steer_a = '0;
    else if (raw_a > DUTY_MAX) steer_a = PWM_WIDTH'(DUTY_MAX);
    else                       steer_a = PWM_WIDTH'(raw_a);
    if (raw_b < 0)             steer_b = '0;
    else if (raw_b > DUTY_MAX) steer_b = PWM_WIDTH'(DUTY_MAX);
    else                       steer_b = PWM_WIDTH'(raw_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_next;
  end

  always_comb begin
    state_next = state_r;
    if (!robot_enabled) begin
      state_next = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:   state_next = S_FOLLOW;
        S_FOLLOW: begin
          if (all_ones && armed && deb_cnt == DEB_W'(NODE_DEBOUNCE - 1)) state_next = S_NODE;
          else if (all_zero)                                              state_next = S_SEARCH;
        end
        S_NODE: begin
          case (dir_lat)
            2'b00:   state_next = S_FOLLOW;
            2'b11:   state_next = S_STOP;
            default: state_next = S_TURN;
          endcase
        end
        S_TURN:   if (timer >= TMR_W'(TURN_MIN) && centre) state_next = S_FOLLOW;
        S_SEARCH: begin
          if (!all_zero)                                state_next = S_FOLLOW;
          else if (timer == TMR_W'(LOST_TIMEOUT - 1))  state_next = S_STOP;
        end
        S_STOP:   state_next = S_STOP;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Arming keeps a held all-ones patch (straight pass through a junction) from counting twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt    <= '0;
      armed      <= 1'b1;
      timer      <= '0;
      node_count <= '0;
      node_pulse <= 1'b0;
      fault      <= 1'b0;
      dir_lat    <= 2'b00;
    end else if (!robot_enabled) begin
      deb_cnt    <= '0;
      armed      <= 1'b1;
      timer      <= '0;
      node_count <= '0;
      node_pulse <= 1'b0;
      fault      <= 1'b0;
    end else begin
      node_pulse <= (state_next == S_NODE);
      if (state_next == S_NODE) begin
        node_count <= node_count + CNT_WIDTH'(1);
        dir_lat    <= turn_direction;
      end
      if (state_r == S_SEARCH && state_next == S_STOP) fault <= 1'b1;
      if (state_next != state_r)
        timer <= '0;
      else if ((state_r == S_TURN || state_r == S_SEARCH) && timer != '1)
        timer <= timer + TMR_W'(1);
      if (state_r == S_FOLLOW && all_ones) begin
        if (deb_cnt < DEB_W'(NODE_DEBOUNCE)) deb_cnt <= deb_cnt + DEB_W'(1);
      end else begin
        deb_cnt <= '0;
      end
      if (state_r == S_NODE || (state_r == S_TURN && state_next == S_FOLLOW))
        armed <= 1'b0;
      else if (state_r != S_TURN && !all_ones)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         last_left <= 1'b0;
    else if (diff < 0) last_left <= 1'b1;
    else if (diff > 0) last_left <= 1'b0;
  end

  // Duty targets are only taken at counter zero so a period never mixes two duties.
  always_comb begin
    tgt_a = '0;
    tgt_b = '0;
    case (state_r)
      S_FOLLOW: begin
        tgt_a = steer_a;
        tgt_b = steer_b;
      end
      S_TURN, S_SEARCH: begin
        tgt_a = PWM_WIDTH'(TURN_DUTY);
        tgt_b = PWM_WIDTH'(TURN_DUTY);
      end
      S_NODE: begin
        tgt_a = duty_a_lat;
        tgt_b = duty_b_lat;
      end
      default: begin
        tgt_a = '0;
        tgt_b = '0;
      end
    endcase
    eff_a = (pwm_cnt == '0) ? tgt_a : duty_a_lat;
    eff_b = (pwm_cnt == '0) ? tgt_b : duty_b_lat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt    <= '0;
      duty_a_lat <= '0;
      duty_b_lat <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
      if (pwm_cnt == '0) begin
        duty_a_lat <= tgt_a;
        duty_b_lat <= tgt_b;
      end
    end
  end

  assign spin_left = (state_r == S_TURN) ? (dir_lat == 2'b01) : last_left;

  // Direction bits are {in1,in2,in3,in4}; left spin reverses A, right spin reverses B.
  always_comb begin
    dir_n = 4'b0000;
    en_n  = 2'b00;
    case (state_r)
      S_FOLLOW: begin
        dir_n = 4'b0101;
        en_n  = {pwm_cnt < eff_a, pwm_cnt < eff_b};
      end
      S_NODE: begin
        dir_n = dir_q;
        en_n  = {pwm_cnt < eff_a, pwm_cnt < eff_b};
      end
      S_TURN, S_SEARCH: begin
        dir_n = spin_left ? 4'b1001 : 4'b0110;
        en_n  = {pwm_cnt < eff_a, pwm_cnt < eff_b};
      end
      default: begin
`ifdef LINE_FOLLOW_BRAKE_EN
        dir_n = 4'b1111;
        en_n  = 2'b11;
`else
        dir_n = 4'b0000;
        en_n  = 2'b00;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q <= 4'b0000;
      en_q  <= 2'b00;
    end else begin
      dir_q <= dir_n;
      en_q  <= en_n;
    end
  end

  assign {in1, in2, in3, in4} = dir_q;
  assign {enA, enB}           = en_q;
  assign state                = state_r;

endmodule

// File: tb/tb_line_follow_ctrl_n.sv
// Directed bench for line_follow_ctrl_n: steering duty table, nodes, turns, search, fault and reset.
module tb_line_follow_ctrl_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       robot_enabled;
  logic [4:0] line_sensor;
  logic [1:0] turn_direction;

  logic       en_a, en_b, in1, in2, in3, in4, node_pulse, fault;
  logic [7:0] node_count;
  logic [2:0] state;
  logic       g_en_a, g_en_b, g_in1, g_in2, g_in3, g_in4, g_node_pulse, g_fault;
  logic [7:0] g_node_count;
  logic [2:0] g_state;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

`ifdef LINE_FOLLOW_BRAKE_EN
  localparam logic [5:0] IDLE_OUT = 6'b111111;
`else
  localparam logic [5:0] IDLE_OUT = 6'b000000;
`endif

  always #5 clk = ~clk;

  line_follow_ctrl_n dut (
    .clk(clk), .reset(reset), .line_sensor(line_sensor), .robot_enabled(robot_enabled),
    .turn_direction(turn_direction), .enA(en_a), .enB(en_b), .in1(in1), .in2(in2),
    .in3(in3), .in4(in4), .node_pulse(node_pulse), .node_count(node_count),
    .fault(fault), .state(state)
  );

  line_follow_ctrl_n #(.GAIN(100)) dut_g (
    .clk(clk), .reset(reset), .line_sensor(line_sensor), .robot_enabled(robot_enabled),
    .turn_direction(turn_direction), .enA(g_en_a), .enB(g_en_b), .in1(g_in1), .in2(g_in2),
    .in3(g_in3), .in4(g_in4), .node_pulse(g_node_pulse), .node_count(g_node_count),
    .fault(g_fault), .state(g_state)
  );

  typedef struct {
    logic [4:0] sens;
    int         duty_a;
    int         duty_b;
    int         g_duty_a;
    int         g_duty_b;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pulses = pulses + int'(node_pulse);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] sens, input logic [1:0] dir);
    line_sensor    = sens;
    turn_direction = dir;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic measure(output int a, output int b, output int ga, output int gb);
    a = 0; b = 0; ga = 0; gb = 0;
    repeat (256) begin
      tick(1);
      a  = a  + int'(en_a);
      b  = b  + int'(en_b);
      ga = ga + int'(g_en_a);
      gb = gb + int'(g_en_b);
    end
  endtask

  initial begin
    int a, b, ga, gb, n;

    vecs[0] = '{5'b00100, 160, 160, 160, 160};
    vecs[1] = '{5'b00011, 208, 112, 255,   0};
    vecs[2] = '{5'b11000, 112, 208,   0, 255};
    vecs[3] = '{5'b00001, 184, 136, 255,  60};
    vecs[4] = '{5'b10000, 136, 184,  60, 255};
    vecs[5] = '{5'b01110, 160, 160, 160, 160};

    reset = 1'b1;
    robot_enabled = 1'b0;
    applyStimulus(5'b00000, 2'b00);
    tick(2);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_outs", {en_a, en_b, in1, in2, in3, in4, node_pulse, fault}, 0);
    checkOutput("reset_count", node_count, 0);

    reset = 1'b0;
    robot_enabled = 1'b1;
    applyStimulus(5'b00100, 2'b00);
    tick(2);
    checkOutput("follow_state", state, 1);
    checkOutput("follow_dir", {in1, in2, in3, in4}, 4'b0101);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].sens, 2'b00);
      tick(300);
      measure(a, b, ga, gb);
      $display("[TB] vector %0d sensor %b", i, vecs[i].sens);
      checkOutput("duty_a", a, vecs[i].duty_a);
      checkOutput("duty_b", b, vecs[i].duty_b);
      checkOutput("gain_duty_a", ga, vecs[i].g_duty_a);
      checkOutput("gain_duty_b", gb, vecs[i].g_duty_b);
      checkOutput("vec_dir", {in1, in2, in3, in4}, 4'b0101);
    end

    // Three all-ones samples fall short of the debounce.
    pulses = 0;
    applyStimulus(5'b11111, 2'b00);
    tick(3);
    applyStimulus(5'b00100, 2'b00);
    tick(5);
    checkOutput("short_node_count", node_count, 0);
    checkOutput("short_node_pulses", pulses, 0);
    checkOutput("short_node_state", state, 1);

    // Qualified node, left turn, early centre ignored.
    pulses = 0;
    applyStimulus(5'b11111, 2'b01);
    tick(4);
    applyStimulus(5'b10000, 2'b01);
    tick(3);
    checkOutput("left_pulses", pulses, 1);
    checkOutput("left_count", node_count, 1);
    checkOutput("left_state", state, 3);
    checkOutput("left_dir", {in1, in2, in3, in4}, 4'b1001);
    tick(93);
    applyStimulus(5'b00100, 2'b01);
    tick(5);
    checkOutput("early_centre_state", state, 3);
    n = 0;
    while (state == 3'd3 && n < 3000) begin
      tick(1);
      n++;
    end
    checkOutput("turn_length", n + 100, 2001);
    tick(1);
    checkOutput("turn_exit_state", state, 1);
    checkOutput("turn_exit_dir", {in1, in2, in3, in4}, 4'b0101);

    // Straight pass: held all-ones after the node must not recount.
    robot_enabled = 1'b0;
    tick(2);
    checkOutput("disable_count", node_count, 0);
    robot_enabled = 1'b1;
    tick(3);
    pulses = 0;
    applyStimulus(5'b11111, 2'b00);
    tick(20);
    checkOutput("straight_count", node_count, 1);
    checkOutput("straight_pulses", pulses, 1);
    checkOutput("straight_state", state, 1);
    checkOutput("straight_dir", {in1, in2, in3, in4}, 4'b0101);
    applyStimulus(5'b00100, 2'b00);
    tick(2);

    // Direction 11 at a node stops without fault.
    applyStimulus(5'b11111, 2'b11);
    tick(4);
    applyStimulus(5'b00100, 2'b11);
    tick(2);
    checkOutput("stop11_state", state, 5);
    checkOutput("stop11_fault", fault, 0);
    checkOutput("stop11_count", node_count, 2);
    checkOutput("stop11_outs", {en_a, en_b, in1, in2, in3, in4}, IDLE_OUT);
    robot_enabled = 1'b0;
    tick(2);
    checkOutput("stop11_idle", state, 0);
    robot_enabled = 1'b1;
    applyStimulus(5'b00100, 2'b00);
    tick(3);

    // Search toward last side (right), recovered by a sensor hit.
    applyStimulus(5'b00001, 2'b00);
    tick(3);
    applyStimulus(5'b00000, 2'b00);
    tick(2);
    checkOutput("search_state", state, 4);
    checkOutput("search_dir", {in1, in2, in3, in4}, 4'b0110);
    tick(28);
    applyStimulus(5'b01000, 2'b00);
    tick(2);
    checkOutput("search_recover", state, 1);

    // One straight node so the later disable has a count to clear.
    applyStimulus(5'b11111, 2'b00);
    tick(4);
    applyStimulus(5'b00100, 2'b00);
    tick(2);
    checkOutput("pre_timeout_count", node_count, 1);

    applyStimulus(5'b00000, 2'b00);
    tick(1);
    n = 0;
    while (state == 3'd4 && n < 60000) begin
      tick(1);
      n++;
    end
    checkOutput("search_length", n, 50000);
    checkOutput("timeout_state", state, 5);
    checkOutput("timeout_fault", fault, 1);
    tick(1);
    checkOutput("timeout_outs", {en_a, en_b, in1, in2, in3, in4}, IDLE_OUT);
    robot_enabled = 1'b0;
    tick(2);
    checkOutput("clear_state", state, 0);
    checkOutput("clear_fault", fault, 0);
    checkOutput("clear_count", node_count, 0);
    checkOutput("idle_outs", {en_a, en_b, in1, in2, in3, in4}, IDLE_OUT);

    // Right turn, then asynchronous reset mid-turn.
    robot_enabled = 1'b1;
    applyStimulus(5'b00100, 2'b00);
    tick(3);
    applyStimulus(5'b11111, 2'b10);
    tick(4);
    applyStimulus(5'b10000, 2'b10);
    tick(10);
    checkOutput("right_state", state, 3);
    checkOutput("right_dir", {in1, in2, in3, in4}, 4'b0110);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_state", state, 0);
    checkOutput("async_reset_outs", {en_a, en_b, in1, in2, in3, in4, node_pulse, fault}, 0);
    checkOutput("async_reset_count", node_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
